// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures the MEM-stage entry, extends sub-word loads, selects the
// writeback value, drives the register-file write port and counts retired
// instructions. Every output comes directly from a flop.
//
// Handshake note: there is no valid/ready pair here. The upstream stage
// presents an entry with in_valid. That entry is taken on every edge where
// stall=0 and flush=0. flush overrides stall and turns the WB slot into a
// bubble. stall holds the slot and everything in it.
module mem_wb_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] ReadData,
    input  logic [WORD_SIZE-1:0] AluResult,
    input  logic [REG_SIZE-1:0]  destination_reg,
    input  logic [1:0]           wb_control_signals,
    input  logic [2:0]           load_funct3,
    output logic                 wb_valid,
    output logic                 reg_write_en,
    output logic [REG_SIZE-1:0]  write_reg,
    output logic [WORD_SIZE-1:0] write_data,
    output logic                 load_misaligned,
    output logic [CNT_W-1:0]     retire_count
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                 w_reg_write;
    logic                 w_mem_to_reg;
    logic [1:0]           w_off;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic                 w_is_half;
    logic                 w_is_word;
    logic [WORD_SIZE-1:0] w_load_ext;
    logic [WORD_SIZE-1:0] w_wb_data;
    logic                 w_misaligned;
    logic                 w_write_en;
    logic                 w_retire;

    logic                 r_wb_valid;
    logic                 r_reg_write_en;
    logic [REG_SIZE-1:0]  r_write_reg;
    logic [WORD_SIZE-1:0] r_write_data;
    logic                 r_load_misaligned;
    logic [CNT_W-1:0]     r_retire_count;

    assign w_reg_write  = wb_control_signals[1];
    assign w_mem_to_reg = wb_control_signals[0];
    assign w_off        = AluResult[1:0];
    assign w_byte       = ReadData[8*w_off +: 8];
    assign w_half       = ReadData[16*w_off[1] +: 16];
    assign w_is_half    = (load_funct3 == F3_LH) || (load_funct3 == F3_LHU);
    // Anything that is not a byte or half load behaves as a full-word load.
    assign w_is_word    = !w_is_half && (load_funct3 != F3_LB) && (load_funct3 != F3_LBU);

    // Sub-word load extension, selected by the load size/sign code.
    always_comb begin
        w_load_ext = ReadData;
        case (load_funct3)
            F3_LB:   w_load_ext = {{(WORD_SIZE-8){w_byte[7]}}, w_byte};
            F3_LH:   w_load_ext = {{(WORD_SIZE-16){w_half[15]}}, w_half};
            F3_LBU:  w_load_ext = {{(WORD_SIZE-8){1'b0}}, w_byte};
            F3_LHU:  w_load_ext = {{(WORD_SIZE-16){1'b0}}, w_half};
            default: w_load_ext = ReadData;
        endcase
    end

    // Misalignment only applies to loads; ALU results ignore the offset.
    assign w_misaligned = in_valid && w_mem_to_reg &&
                          ((w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00)));
    assign w_wb_data    = w_mem_to_reg ? w_load_ext : AluResult;
    // Write enable is resolved before the flop so the output is registered.
    assign w_write_en   = in_valid && w_reg_write && (destination_reg != '0) && !w_misaligned;
    assign w_retire     = r_wb_valid && !stall && !flush;

    // WB entry register: flush makes a bubble, stall holds, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid        <= 1'b0;
            r_reg_write_en    <= 1'b0;
            r_write_reg       <= '0;
            r_write_data      <= '0;
            r_load_misaligned <= 1'b0;
        end else if (flush) begin
            r_wb_valid        <= 1'b0;
            r_reg_write_en    <= 1'b0;
            r_load_misaligned <= 1'b0;
        end else if (!stall) begin
            r_wb_valid        <= in_valid;
            r_reg_write_en    <= w_write_en;
            r_write_reg       <= destination_reg;
            r_write_data      <= w_wb_data;
            r_load_misaligned <= w_misaligned;
        end
    end

    // Retired-instruction counter; wraps silently at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + 1'b1;
        end
    end

    assign wb_valid        = r_wb_valid;
    assign reg_write_en    = r_reg_write_en;
    assign write_reg       = r_write_reg;
    assign write_data      = r_write_data;
    assign load_misaligned = r_load_misaligned;
    assign retire_count    = r_retire_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] ReadData;
    logic [31:0] AluResult;
    logic [4:0]  destination_reg;
    logic [1:0]  wb_control_signals;
    logic [2:0]  load_funct3;

    logic        wb_valid;
    logic        reg_write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        load_misaligned;
    logic [31:0] retire_count;

    logic        n_wb_valid;
    logic        n_reg_write_en;
    logic [4:0]  n_write_reg;
    logic [31:0] n_write_data;
    logic        n_load_misaligned;
    logic [3:0]  n_retire_count;

    int checks;
    int errors;

    mem_wb_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .flush              (flush),
        .in_valid           (in_valid),
        .ReadData           (ReadData),
        .AluResult          (AluResult),
        .destination_reg    (destination_reg),
        .wb_control_signals (wb_control_signals),
        .load_funct3        (load_funct3),
        .wb_valid           (wb_valid),
        .reg_write_en       (reg_write_en),
        .write_reg          (write_reg),
        .write_data         (write_data),
        .load_misaligned    (load_misaligned),
        .retire_count       (retire_count)
    );

    // Narrow-counter instance shares the stimulus; used for the wrap check.
    mem_wb_stage #(.CNT_W(4)) dut_narrow (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .flush              (flush),
        .in_valid           (in_valid),
        .ReadData           (ReadData),
        .AluResult          (AluResult),
        .destination_reg    (destination_reg),
        .wb_control_signals (wb_control_signals),
        .load_funct3        (load_funct3),
        .wb_valid           (n_wb_valid),
        .reg_write_en       (n_reg_write_en),
        .write_reg          (n_write_reg),
        .write_data         (n_write_data),
        .load_misaligned    (n_load_misaligned),
        .retire_count       (n_retire_count)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] rd_data, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [1:0] ctl, input logic [2:0] f3);
        in_valid           = v;
        ReadData           = rd_data;
        AluResult          = alu;
        destination_reg    = rd;
        wb_control_signals = ctl;
        load_funct3        = f3;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 3'b000);
        #12;
        check_val("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        check_val("rst_rwe", {31'b0, reg_write_en}, 32'h0);
        check_val("rst_wdata", write_data, 32'h0);
        check_val("rst_count", retire_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // lb at offset 2: byte 0xFF sign-extends
        drive(1'b1, 32'h80FF7F01, 32'h00000102, 5'd5, 2'b11, 3'b000);
        step();
        check_val("lb_wdata", write_data, 32'hFFFFFFFF);
        check_val("lb_wreg", {27'b0, write_reg}, 32'd5);
        check_val("lb_rwe", {31'b0, reg_write_en}, 32'h1);
        check_val("lb_valid", {31'b0, wb_valid}, 32'h1);
        check_val("lb_count", retire_count, 32'd0);

        // lbu at offset 2: byte zero-extends
        drive(1'b1, 32'h80FF7F01, 32'h00000102, 5'd5, 2'b11, 3'b100);
        step();
        check_val("lbu_wdata", write_data, 32'h000000FF);
        check_val("lbu_count", retire_count, 32'd1);

        // lh at offset 2: upper half 0x80FF sign-extends
        drive(1'b1, 32'h80FF7F01, 32'h00000102, 5'd6, 2'b11, 3'b001);
        step();
        check_val("lh_wdata", write_data, 32'hFFFF80FF);
        check_val("lh_misal", {31'b0, load_misaligned}, 32'h0);

        // lhu at offset 0: lower half 0x7F01
        drive(1'b1, 32'h80FF7F01, 32'h00000100, 5'd6, 2'b11, 3'b101);
        step();
        check_val("lhu_wdata", write_data, 32'h00007F01);

        // aligned lw
        drive(1'b1, 32'hDEADBEEF, 32'h00000200, 5'd9, 2'b11, 3'b010);
        step();
        check_val("lw_wdata", write_data, 32'hDEADBEEF);
        check_val("lw_rwe", {31'b0, reg_write_en}, 32'h1);
        check_val("lw_count", retire_count, 32'd4);

        // R-type to x0: data passes, no write
        drive(1'b1, 32'hCAFEF00D, 32'h00001234, 5'd0, 2'b10, 3'b000);
        step();
        check_val("x0_wdata", write_data, 32'h00001234);
        check_val("x0_rwe", {31'b0, reg_write_en}, 32'h0);

        // misaligned lh at 0x103
        drive(1'b1, 32'h11223344, 32'h00000103, 5'd3, 2'b11, 3'b001);
        step();
        check_val("misal_flag", {31'b0, load_misaligned}, 32'h1);
        check_val("misal_rwe", {31'b0, reg_write_en}, 32'h0);
        check_val("misal_count", retire_count, 32'd6);

        // valid entry rd=7, then stall three cycles with changing inputs
        drive(1'b1, 32'h0, 32'h00000077, 5'd7, 2'b10, 3'b000);
        step();
        check_val("pre_stall_count", retire_count, 32'd7);
        check_val("misal_retired_clear", {31'b0, load_misaligned}, 32'h0);
        stall = 1'b1;
        drive(1'b1, 32'h0, 32'h00000088, 5'd8, 2'b10, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_wreg", {27'b0, write_reg}, 32'd7);
            check_val("stall_wdata", write_data, 32'h00000077);
            check_val("stall_rwe", {31'b0, reg_write_en}, 32'h1);
            check_val("stall_count", retire_count, 32'd7);
        end
        stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 3'b000);
        step();
        check_val("release_count", retire_count, 32'd8);
        check_val("release_valid", {31'b0, wb_valid}, 32'h0);

        // stall and flush together: flush wins, nothing retires
        drive(1'b1, 32'h0, 32'h000000AA, 5'd10, 2'b10, 3'b000);
        step();
        check_val("sf_pre_valid", {31'b0, wb_valid}, 32'h1);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check_val("sf_valid", {31'b0, wb_valid}, 32'h0);
        check_val("sf_rwe", {31'b0, reg_write_en}, 32'h0);
        check_val("sf_wdata_hold", write_data, 32'h000000AA);
        check_val("sf_count", retire_count, 32'd8);
        stall = 1'b0;
        flush = 1'b0;

        // invalid entry with RegWrite high writes nothing
        drive(1'b0, 32'h0, 32'h00000055, 5'd4, 2'b10, 3'b000);
        step();
        check_val("inv_rwe", {31'b0, reg_write_en}, 32'h0);
        check_val("inv_count", retire_count, 32'd8);

        // reset mid-stream between edges
        drive(1'b1, 32'h01020304, 32'h00000300, 5'd12, 2'b11, 3'b010);
        step();
        check_val("pre_rst_rwe", {31'b0, reg_write_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {31'b0, wb_valid}, 32'h0);
        check_val("mid_rst_rwe", {31'b0, reg_write_en}, 32'h0);
        check_val("mid_rst_wreg", {27'b0, write_reg}, 32'h0);
        check_val("mid_rst_wdata", write_data, 32'h0);
        check_val("mid_rst_count", retire_count, 32'h0);
        check_val("mid_rst_ncount", {28'b0, n_retire_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // retire a stream of valid entries: 4-bit counter wraps 15 -> 0
        drive(1'b1, 32'h0, 32'h00000001, 5'd1, 2'b10, 3'b000);
        for (int i = 0; i < 16; i++) step();
        check_val("wrap_before", {28'b0, n_retire_count}, 32'd15);
        step();
        check_val("wrap_after", {28'b0, n_retire_count}, 32'd0);
        check_val("wide_count", retire_count, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
